gg_nal_stream_ctrl: RTL
=======================

# gg_nal_stream_ctrl

Sequencer that feeds the NAL lattice parser from a valid/ready RBSP word stream. It builds the current word plus its 32-bit lookahead pad, and issues the single stream-start trigger. It advances the lattice only when a full window is available and tracks slice start/end events from the lattice and slice parser. It sits between the emulation-prevention stripper and `gg_parse_nal_lattice`.

## Interface
- WIDTH, 32: bits per word; multiple of 8, ≥32
- BYTE_WIDTH, WIDTH/8: byte lanes per word
- CNT_W, 32: width of byte/slice counters
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse; begin a new stream (ignored unless IDLE or DONE)
- in_data  in  WIDTH  RBSP word, big-endian packed
- in_valid  in  1  word available
- in_last  in  1  qualifies final word of stream
- in_ready  out  1  word accepted when in_valid & in_ready
- lat_bits  out  WIDTH  current word to lattice `in_bits`
- lat_pad  out  32  lookahead to lattice `in_pad`
- lat_en  out  1  window consumed this cycle; lattice state registers update only when high
- lat_nal_start  out  BYTE_WIDTH  to lattice `nal_start`
- lat_slice_start  in  BYTE_WIDTH  from lattice `slice_start`
- lat_slice_end  in  BYTE_WIDTH  from slice parser `slice_end`
- busy  out  1  not IDLE/DONE
- done  out  1  stream fully consumed; held until start/reset
- slice_active  out  1  slice started, not yet ended
- err_overlap  out  1  sticky; slice_start seen while slice_active
- byte_cnt  out  CNT_W  bytes consumed this stream

## Operation
- Two-entry buffer: `cur` (presented word) and `nxt` (lookahead source). `lat_pad` = `nxt[WIDTH-1 -: 32]`, or 0 when `nxt` holds the flushed tail.
- States:
  - IDLE: in_ready=0. start → FILL.
  - FILL: in_ready=1. Load `cur`, then `nxt`. When both are valid → RUN. If in_last arrives on the `cur` load → TAIL.
  - RUN: lat_en=1 when `nxt` is valid. On lat_en, `cur`←`nxt`, and `nxt`←accepted word if one is accepted the same cycle, otherwise `nxt` is empty. in_ready=1 unless `nxt` is full and lat_en=0. Accepting the in_last word → TAIL after that word moves to `nxt`.
  - TAIL: no further input accepted. Lattice consumes the remaining `cur`/`nxt` words. The final word is presented with lat_pad=0. After the final lat_en → DONE.
  - DONE: done=1, in_ready=0. start → FILL, which clears counters and flags.
- lat_nal_start = {1'b1, (BYTE_WIDTH-1)'b0} on the first lat_en cycle of each stream only; otherwise 0.
- slice_active is set on any lat_slice_start bit while lat_en=1, and cleared on any lat_slice_end bit. If both occur in the same cycle, the end applies first, then the start, so slice_active stays 1.
- err_overlap is set when a slice_start occurs with slice_active=1 and no same-cycle end.
- byte_cnt += BYTE_WIDTH per lat_en, saturating at all-ones.
- Starvation in RUN (`nxt` empty, in_valid=0): lat_en=0 and lat_bits holds. The lattice must not advance.

## Timing
- Reset values: in_ready=0, lat_en=0, lat_nal_start=0, lat_bits=0, lat_pad=0, busy=0, done=0, slice_active=0, err_overlap=0, byte_cnt=0. State=IDLE.
- All outputs are registered, except lat_en and in_ready, which are combinational from state and buffer occupancy.
- Startup latency: with in_valid held high, the first lat_en occurs 3 cycles after start (1 cycle to FILL, 2 loads).
- Steady state: 1 word per cycle with no bubbles.
- Reset mid-stream: buffers are discarded and state returns to IDLE next cycle.
- start while busy is ignored.

## Configuration
- `GG_NAL_CTRL_STATS_EN` defined: add output `slice_cnt[CNT_W-1:0]`. It counts lat_slice_start events per stream, saturating, cleared on start or reset.
- Undefined: `slice_cnt` port and logic are absent.

## Structure
- `gg_nal_pkg`: state enum `nal_ctrl_state_t` {IDLE, FILL, RUN, TAIL, DONE} and the constant PAD_BITS=32.
- Sub-module `gg_nal_window_buf`: 2-entry cur/nxt buffer with the accept/advance logic. The FSM, flags and counters stay in the top.

## Test plan
- Continuous 4-word stream (WIDTH=32), last on word 4 → lat_en high for exactly 4 consecutive cycles starting 3 cycles after start. Final lat_pad=0. done=1. byte_cnt=16.
- in_valid drops for 2 cycles mid-RUN → lat_en low for those cycles, lat_bits stable, no word lost or duplicated (compare against the scoreboard sequence).
- lat_nal_start = 4'b1000 on the first lat_en only. A second stream after done again pulses it once.
- slice_start 4'b0100, then slice_end 4'b0001 two cycles later → slice_active high for 2 cycles, err_overlap=0. A second slice_start before the end → err_overlap=1, sticky.
- Reset asserted in RUN with 2 buffered words → next cycle all outputs are at reset values and in_ready=0.
- With `GG_NAL_CTRL_STATS_EN` defined, 3 slice starts → slice_cnt=3, cleared to 0 on the next start.

Source files
------------

// File: rtl/gg_nal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gg_nal_pkg
// Description : Shared types and constants for the NAL stream sequencer.
//               nal_ctrl_state_t - sequencer states
//               PAD_BITS         - width of the lattice lookahead pad
// Revision    : 1.0 - initial release
// ============================================================================
package gg_nal_pkg;

    localparam int PAD_BITS = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        RUN  = 3'd2,
        TAIL = 3'd3,
        DONE = 3'd4
    } nal_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/gg_nal_window_buf.sv
`default_nettype none
// ============================================================================
// Module      : gg_nal_window_buf
// Description : Two-entry cur/nxt word buffer feeding the lattice window.
//               cur is the presented word; nxt supplies the lookahead pad.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               clear        - empty both entries (new stream)
//               load, data   - word accepted this cycle
//               advance      - window consumed: cur<=nxt
//               cur_data     - presented word (registered)
//               pad          - top PAD_BITS of nxt, 0 when nxt empty
//               cur_valid, nxt_valid - occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module gg_nal_window_buf
    import gg_nal_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [WIDTH-1:0]    data,
    input  logic                advance,
    output logic [WIDTH-1:0]    cur_data,
    output logic [PAD_BITS-1:0] pad,
    output logic                cur_valid,
    output logic                nxt_valid
);

    logic [WIDTH-1:0]    r_cur;
    logic [WIDTH-1:0]    r_nxt;
    logic [PAD_BITS-1:0] r_pad;
    logic                r_cur_valid;
    logic                r_nxt_valid;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cur       <= '0;
            r_nxt       <= '0;
            r_pad       <= '0;
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
        end else if (advance) begin
            // cur data is left alone when nxt is empty so lat_bits holds
            // the last presented word after the tail drains.
            if (r_nxt_valid) begin
                r_cur <= r_nxt;
            end
            r_cur_valid <= r_nxt_valid;
            if (load) begin
                r_nxt       <= data;
                r_pad       <= data[WIDTH-1 -: PAD_BITS];
                r_nxt_valid <= 1'b1;
            end else begin
                r_pad       <= '0;
                r_nxt_valid <= 1'b0;
            end
        end else if (load) begin
            if (!r_cur_valid) begin
                r_cur       <= data;
                r_cur_valid <= 1'b1;
            end else begin
                r_nxt       <= data;
                r_pad       <= data[WIDTH-1 -: PAD_BITS];
                r_nxt_valid <= 1'b1;
            end
        end
    end

    assign cur_data  = r_cur;
    assign pad       = r_pad;
    assign cur_valid = r_cur_valid;
    assign nxt_valid = r_nxt_valid;

endmodule
`default_nettype wire

// File: rtl/gg_nal_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gg_nal_stream_ctrl
// Description : Sequencer between the emulation-prevention stripper and the
//               NAL lattice parser. Builds word + 32-bit lookahead, issues the
//               stream-start trigger, advances the lattice only on a full
//               window and tracks slice start/end events.
// Ports       : clk, reset (sync, active-high), start
//               in_data/in_valid/in_last/in_ready  - RBSP word stream
//               lat_bits/lat_pad/lat_en/lat_nal_start - to lattice
//               lat_slice_start/lat_slice_end      - slice events
//               busy, done, slice_active, err_overlap, byte_cnt
// Config      : GG_NAL_CTRL_STATS_EN adds output slice_cnt (slice starts
//               per stream, saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module gg_nal_stream_ctrl
    import gg_nal_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = WIDTH / 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      lat_bits,
    output logic [PAD_BITS-1:0]   lat_pad,
    output logic                  lat_en,
    output logic [BYTE_WIDTH-1:0] lat_nal_start,
    input  logic [BYTE_WIDTH-1:0] lat_slice_start,
    input  logic [BYTE_WIDTH-1:0] lat_slice_end,
    output logic                  busy,
    output logic                  done,
    output logic                  slice_active,
    output logic                  err_overlap,
    output logic [CNT_W-1:0]      byte_cnt
`ifdef GG_NAL_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]      slice_cnt
`endif
);

    nal_ctrl_state_t r_state;
    nal_ctrl_state_t w_state_next;

    logic w_cur_valid;
    logic w_nxt_valid;
    logic w_load;
    logic w_start_go;
    logic w_start_hit;
    logic w_end_hit;

    logic [BYTE_WIDTH-1:0] r_nal_start;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_slice_active;
    logic                  r_err_overlap;
    logic [CNT_W-1:0]      r_byte_cnt;
    logic [CNT_W:0]        w_byte_sum;

    assign w_start_go  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_load      = in_valid && in_ready;
    assign w_start_hit = lat_en && (|lat_slice_start);
    assign w_end_hit   = |lat_slice_end;
    assign w_byte_sum  = {1'b0, r_byte_cnt} + (CNT_W + 1)'(BYTE_WIDTH);

    gg_nal_window_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (w_start_go),
        .load      (w_load),
        .data      (in_data),
        .advance   (lat_en),
        .cur_data  (lat_bits),
        .pad       (lat_pad),
        .cur_valid (w_cur_valid),
        .nxt_valid (w_nxt_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        lat_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last) begin
                        w_state_next = TAIL;
                    end else if (w_cur_valid) begin
                        w_state_next = RUN;
                    end
                end
            end
            RUN: begin
                lat_en   = w_nxt_valid;
                in_ready = !w_nxt_valid || lat_en;
                if (in_valid && in_last) begin
                    w_state_next = TAIL;
                end
            end
            TAIL: begin
                // cur is always valid until the final word is consumed.
                lat_en = w_cur_valid;
                if (lat_en && !w_nxt_valid) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Leaving FILL always lands on a full window (RUN with both entries, or
    // TAIL with at least cur), so the first lat_en is exactly the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_nal_start <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_nal_start <= ((r_state == FILL) && (w_state_next != FILL)) ?
                           {1'b1, {(BYTE_WIDTH - 1){1'b0}}} : '0;
            r_busy      <= (w_state_next == FILL) || (w_state_next == RUN) ||
                           (w_state_next == TAIL);
            r_done      <= (w_state_next == DONE);
        end
    end

    // End is applied before start, so a same-cycle end+start leaves the
    // slice open and is not an overlap.
    always_ff @(posedge clk) begin
        if (reset || w_start_go) begin
            r_slice_active <= 1'b0;
            r_err_overlap  <= 1'b0;
            r_byte_cnt     <= '0;
        end else begin
            if (w_start_hit && r_slice_active && !w_end_hit) begin
                r_err_overlap <= 1'b1;
            end
            if (w_start_hit) begin
                r_slice_active <= 1'b1;
            end else if (w_end_hit) begin
                r_slice_active <= 1'b0;
            end
            if (lat_en) begin
                r_byte_cnt <= w_byte_sum[CNT_W] ? '1 : w_byte_sum[CNT_W-1:0];
            end
        end
    end

`ifdef GG_NAL_CTRL_STATS_EN
    logic [CNT_W-1:0] r_slice_cnt;
    logic [CNT_W:0]   w_slice_sum;

    assign w_slice_sum = {1'b0, r_slice_cnt} + (CNT_W + 1)'(1);

    always_ff @(posedge clk) begin
        if (reset || w_start_go) begin
            r_slice_cnt <= '0;
        end else if (w_start_hit) begin
            r_slice_cnt <= w_slice_sum[CNT_W] ? '1 : w_slice_sum[CNT_W-1:0];
        end
    end

    assign slice_cnt = r_slice_cnt;
`endif

    assign lat_nal_start = r_nal_start;
    assign busy          = r_busy;
    assign done          = r_done;
    assign slice_active  = r_slice_active;
    assign err_overlap   = r_err_overlap;
    assign byte_cnt      = r_byte_cnt;

endmodule
`default_nettype wire
